// File: rtl/pdm_audio_pkg.sv
// Shared helpers for the multi-channel PDM output stage: frame-counter
// width and the signed-to-offset-binary conversion used by each modulator.
package pdm_audio_pkg;

    localparam int MAX_W = 64;

    function automatic int cnt_width(input int osr);
        return (osr > 2) ? $clog2(osr) : 1;
    endfunction

    // Flipping the sign bit maps -2^(w-1)..2^(w-1)-1 onto 0..2^w-1
    function automatic logic [MAX_W-1:0] to_offset(input logic [MAX_W-1:0] x, input int w);
        logic [MAX_W-1:0] one_v;
        one_v = {{(MAX_W-1){1'b0}}, 1'b1};
        return x ^ (one_v << (w - 1));
    endfunction

endpackage

// File: rtl/pdm_dsm1.sv
// First-order delta-sigma modulator: the accumulator carry is the bitstream,
// so wrap of the accumulator is the modulation and no saturation is needed.
module pdm_dsm1
    import pdm_audio_pkg::*;
#(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic [W-1:0] din,
    output logic         dout
);

    logic [W-1:0] u_s;
    logic [W:0]   sum_s;
    logic [W-1:0] acc_r;

    assign u_s   = W'(to_offset(MAX_W'(din), W));
    assign sum_s = {1'b0, acc_r} + {1'b0, u_s};

    // Accumulate offset-binary input; emit carry, clear while disabled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_r <= '0;
            dout  <= 1'b0;
        end else if (!en) begin
            acc_r <= '0;
            dout  <= 1'b0;
        end else begin
            acc_r <= sum_s[W-1:0];
            dout  <= sum_s[W];
        end
    end

endmodule

// File: rtl/pdm_audio_mc.sv
// Multi-channel FIFO-to-PDM output stage: one packed frame per OSR clocks,
// per-channel sample registers, underrun reporting and mute.
module pdm_audio_mc
    import pdm_audio_pkg::*;
#(
    parameter int CH   = 2,
    parameter int W    = 16,
    parameter int OSR  = 32,
    parameter int HOLD = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en,
    input  logic            mute,
    input  logic            rdaccess,
    output logic            rden,
    input  logic [CH*W-1:0] rddat,
    output logic            underrun,
    output logic [CH-1:0]   pdm
);

    localparam int             FCW     = cnt_width(OSR);
    localparam logic [FCW-1:0] FC_LAST = FCW'(OSR - 1);

    logic [FCW-1:0] fcnt_r;
    logic           boundary_s;

    // Frame counter, parked at zero while disabled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fcnt_r <= '0;
        end else if (!en) begin
            fcnt_r <= '0;
        end else if (fcnt_r == FC_LAST) begin
            fcnt_r <= '0;
        end else begin
            fcnt_r <= fcnt_r + FCW'(1);
        end
    end

    // Boundary strobes: read when the FIFO has data, otherwise flag underrun
    always_comb begin
        boundary_s = en & (fcnt_r == FC_LAST);
        rden       = boundary_s & rdaccess;
        underrun   = boundary_s & ~rdaccess;
    end

    for (genvar k = 0; k < CH; k++) begin : g_ch
        logic [W-1:0] smp_r;
        logic [W-1:0] din_s;

        // Sample register: load on a read, hold or clear on underrun
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                smp_r <= '0;
            end else if (rden) begin
                smp_r <= rddat[k*W +: W];
            end else if (underrun && (HOLD == 0)) begin
                smp_r <= '0;
            end else begin
                smp_r <= smp_r;
            end
        end

        // Mute only gates the modulator input; reads keep draining the FIFO
        assign din_s = mute ? '0 : smp_r;

        pdm_dsm1 #(
            .W(W)
        ) u_dsm (
            .clk  (clk),
            .rst_n(rst_n),
            .en   (en),
            .din  (din_s),
            .dout (pdm[k])
        );
    end

endmodule

// File: tb/tb_pdm_audio_mc.sv
// Scoreboard bench for pdm_audio_mc: a HOLD=1 and a HOLD=0 instance share
// stimulus; strobes and ones-density windows are checked by a monitor.
module tb_pdm_audio_mc;

    localparam int CH  = 2;
    localparam int W   = 16;
    localparam int OSR = 32;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            en;
    logic            mute;
    logic            rdaccess;
    logic [CH*W-1:0] rddat;
    logic            rden, rden2;
    logic            underrun, underrun2;
    logic [CH-1:0]   pdm, pdm2;

    pdm_audio_mc #(.CH(CH), .W(W), .OSR(OSR), .HOLD(1)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .mute(mute), .rdaccess(rdaccess),
        .rden(rden), .rddat(rddat), .underrun(underrun), .pdm(pdm)
    );

    pdm_audio_mc #(.CH(CH), .W(W), .OSR(OSR), .HOLD(0)) dut_h0 (
        .clk(clk), .rst_n(rst_n), .en(en), .mute(mute), .rdaccess(rdaccess),
        .rden(rden2), .rddat(rddat), .underrun(underrun2), .pdm(pdm2)
    );

    always #5 clk = ~clk;

    typedef struct {
        int cyc;
        bit is_ur;
    } ev_t;

    typedef struct {
        int first;
        int last;
        int sel;
        int exp;
    } win_t;

    ev_t  ev_q[$];
    win_t win_q[$];

    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc      = 0;
    bit   run      = 1'b0;
    logic [3:0] hist [0:1023];

    // Expected strobe cycles, counted from the cycle en rises (cycle 0)
    localparam int N_EV   = 16;
    localparam int UR_CYC = 383;
    localparam int EV_CYC [N_EV] = '{31, 63, 95, 127, 159, 191, 223, 255,
                                     287, 319, 351, 383, 415, 447, 499, 531};

    // Density windows: sel 0/1 = HOLD=1 ch0/ch1, sel 2/3 = HOLD=0 ch0/ch1
    localparam int N_WIN = 18;
    localparam int W_FIRST [N_WIN] = '{32, 32, 130, 130, 130, 130, 226, 226, 296,
                                       364, 385, 385, 465, 465, 465, 465, 469, 469};
    localparam int W_LAST  [N_WIN] = '{95, 95, 193, 193, 193, 193, 289, 289, 359,
                                       379, 416, 416, 467, 467, 467, 467, 500, 500};
    localparam int W_SEL   [N_WIN] = '{0, 1, 0, 1, 2, 3, 0, 1, 0,
                                       0, 0, 2, 0, 1, 2, 3, 0, 2};
    localparam int W_EXP   [N_WIN] = '{32, 32, 0, 64, 0, 64, 48, 32, 32,
                                       12, 24, 16, 0, 0, 0, 0, 16, 16};

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    always @(posedge clk) begin
        if (!run) cyc <= 0;
        else      cyc <= cyc + 1;
    end

    // Monitor: compares strobes and density windows as the DUT presents them
    initial begin
        ev_t e;
        int  ones;
        forever begin
            @(negedge clk);
            if (run) begin
                if (cyc < 1024) hist[cyc] = {pdm2, pdm};

                while (ev_q.size() > 0 && ev_q[0].cyc < cyc) begin
                    e = ev_q.pop_front();
                    check($sformatf("missed_strobe_at_%0d", e.cyc), cyc, e.cyc);
                end

                if (rden || underrun) begin
                    check($sformatf("strobe_exclusive_%0d", cyc), int'(rden & underrun), 0);
                    if (ev_q.size() == 0) begin
                        check("unexpected_strobe", cyc, -1);
                    end else begin
                        e = ev_q.pop_front();
                        check(underrun ? "underrun_cycle" : "rden_cycle", cyc, e.cyc);
                        check($sformatf("strobe_kind_%0d", e.cyc), int'(underrun), int'(e.is_ur));
                    end
                end

                for (int i = win_q.size() - 1; i >= 0; i--) begin
                    if (win_q[i].last == cyc) begin
                        ones = 0;
                        for (int c = win_q[i].first; c <= win_q[i].last; c++) begin
                            ones += int'(hist[c][win_q[i].sel]);
                        end
                        check($sformatf("ones_sel%0d_%0d_%0d", win_q[i].sel,
                                        win_q[i].first, win_q[i].last), ones, win_q[i].exp);
                        win_q.delete(i);
                    end
                end
            end
        end
    end

    // Stimulus: directed frames, mute, one underrun and a mid-frame reset
    initial begin
        ev_t  e;
        win_t w;
        rst_n    = 1'b0;
        en       = 1'b0;
        mute     = 1'b0;
        rdaccess = 1'b1;
        rddat    = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_pdm",      int'(pdm),      0);
        check("reset_pdm_h0",   int'(pdm2),     0);
        check("reset_rden",     int'(rden),     0);
        check("reset_underrun", int'(underrun), 0);

        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        en  = 1'b1;
        run = 1'b1;

        for (int c = 0; c < 545; c++) begin
            for (int j = 0; j < N_EV; j++) begin
                if (EV_CYC[j] == c) begin
                    e.cyc   = c;
                    e.is_ur = (c == UR_CYC);
                    ev_q.push_back(e);
                end
            end
            for (int j = 0; j < N_WIN; j++) begin
                if (W_FIRST[j] == c) begin
                    w.first = W_FIRST[j];
                    w.last  = W_LAST[j];
                    w.sel   = W_SEL[j];
                    w.exp   = W_EXP[j];
                    win_q.push_back(w);
                end
            end

            if (c == 96)     rddat = {16'h7FFF, 16'h8000};
            if (c == 192)    rddat = {16'h0000, 16'h4000};
            if (c == 292)    mute = 1'b1;
            if (c == 362)    mute = 1'b0;
            if (c == UR_CYC) rdaccess = 1'b0;
            if (c == 384)    rdaccess = 1'b1;
            if (c == 465)    rst_n = 1'b0;
            if (c == 468)    rst_n = 1'b1;

            @(posedge clk);
            #1;
        end

        check("events_drained",  ev_q.size(),  0);
        check("windows_drained", win_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
